// File: rtl/hazard_stall_unit_pkg.sv
// Shared types and constants for the hazard stall unit.
// Pure declarations; no logic or latency.
// No flow control of its own.
package hazard_stall_unit_pkg;

    // Tuse of 3 marks a source the instruction never reads.
    localparam logic [1:0] TUSE_NONE = 2'd3;

    // Tnew encodings as seen by the instruction sitting in EX.
    localparam logic [1:0] TNEW_NONE = 2'd0;
    localparam logic [1:0] TNEW_ALU  = 2'd1;
    localparam logic [1:0] TNEW_LOAD = 2'd2;

    // MDU occupancy after a start op is accepted in EX.
    localparam int MULT_CYCLES = 5;
    localparam int DIV_CYCLES  = 10;

    // Shadow of the instruction occupying the EX stage.
    typedef struct packed {
        logic [4:0] wa;
        logic [1:0] tnew;
        logic       md_use;
        logic       md_start;
        logic       md_div;
    } ex_slot_t;

    // Shadow of the instruction occupying the MEM stage.
    typedef struct packed {
        logic [4:0] wa;
        logic [1:0] tnew;
    } mem_slot_t;

    // Tnew one stage further down the pipe, saturating at zero.
    function automatic logic [1:0] tnew_age(input logic [1:0] tnew);
        return (tnew == TNEW_NONE) ? TNEW_NONE : tnew - 2'd1;
    endfunction

    // A source stalls when an in-flight producer delivers later than the source needs it.
    function automatic logic src_hazard(input logic [4:0] src, input logic [1:0] tuse,
                                        input ex_slot_t ex, input mem_slot_t mem);
        return (src != 5'd0) &&
               (((ex.wa == src)  && (ex.tnew  > tuse)) ||
                ((mem.wa == src) && (mem.tnew > tuse)));
    endfunction

endpackage

// File: rtl/hazard_stall_unit_mdu_busy_counter.sv
// MDU busy counter: loads on a start op leaving EX, then counts down to idle.
// busy is combinational from the count register (zero-cycle).
// hold blocks the load while the start op is frozen in EX; counting continues.
module mdu_busy_counter #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic is_div,
    input  logic hold,
    output logic busy
);

    logic [CNT_W-1:0] cnt;

    // Load wins over decrement; reset abandons any count in progress.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (start && !hold) begin
            cnt <= is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
        end else if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign busy = (cnt != '0);

endmodule

// File: rtl/hazard_stall_unit.sv
// Hazard detection: ID-stage stall for register data hazards, EX-stage stall for MDU conflicts.
// Outputs are combinational from slot state and ID fields (zero-cycle latency).
// stall_ex freezes EX and bubbles MEM; stall_id bubbles EX and is suppressed under stall_ex.
module hazard_stall_unit
    import hazard_stall_unit_pkg::*;
#(
    parameter int MULT_CYCLES = hazard_stall_unit_pkg::MULT_CYCLES,
    parameter int DIV_CYCLES  = hazard_stall_unit_pkg::DIV_CYCLES,
    parameter int CNT_W       = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic [1:0] id_tuse_rs,
    input  logic [1:0] id_tuse_rt,
    input  logic [4:0] id_wa,
    input  logic [1:0] id_tnew,
    input  logic       id_md_use,
    input  logic       id_md_start,
    input  logic       id_md_div,
    output logic       stall_id,
    output logic       stall_ex,
    output logic       md_busy
);

    ex_slot_t  ex_q;
    mem_slot_t mem_q;
    ex_slot_t  id_slot;
    logic      data_hazard;
    logic      md_conflict;

    assign id_slot = '{wa: id_wa, tnew: id_tnew, md_use: id_md_use,
                       md_start: id_md_start, md_div: id_md_div};

    // Stall decisions; stall_ex has priority because the controller favours IF/ID
    // and would otherwise overwrite the frozen EX instruction with a bubble.
    always_comb begin
        data_hazard = src_hazard(id_rs, id_tuse_rs, ex_q, mem_q) ||
                      src_hazard(id_rt, id_tuse_rt, ex_q, mem_q);
        md_conflict = ex_q.md_use && md_busy;
        stall_ex    = !reset && md_conflict;
        stall_id    = !reset && data_hazard && !md_conflict;
    end

    // Shadow of the EX and MEM pipeline slots, advanced the same way the real pipe moves.
    always_ff @(posedge clk) begin
        if (reset) begin
            ex_q  <= '0;
            mem_q <= '0;
        end else if (stall_ex) begin
            mem_q <= '0;
        end else begin
            mem_q <= '{wa: ex_q.wa, tnew: tnew_age(ex_q.tnew)};
            ex_q  <= stall_id ? ex_slot_t'('0) : id_slot;
        end
    end

    mdu_busy_counter #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES),
        .CNT_W       (CNT_W)
    ) u_mdu_busy_counter (
        .clk    (clk),
        .reset  (reset),
        .start  (ex_q.md_start),
        .is_div (ex_q.md_div),
        .hold   (stall_ex),
        .busy   (md_busy)
    );

endmodule

// File: tb/tb_hazard_stall_unit.sv
module tb_hazard_stall_unit;
    import hazard_stall_unit_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] id_rs, id_rt, id_wa;
    logic [1:0] id_tuse_rs, id_tuse_rt, id_tnew;
    logic       id_md_use, id_md_start, id_md_div;
    logic       stall_id, stall_ex, md_busy;

    int n_checks = 0;
    int n_err    = 0;

    hazard_stall_unit dut (
        .clk         (clk),
        .reset       (reset),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_tuse_rs  (id_tuse_rs),
        .id_tuse_rt  (id_tuse_rt),
        .id_wa       (id_wa),
        .id_tnew     (id_tnew),
        .id_md_use   (id_md_use),
        .id_md_start (id_md_start),
        .id_md_div   (id_md_div),
        .stall_id    (stall_id),
        .stall_ex    (stall_ex),
        .md_busy     (md_busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic id_in(input logic [4:0] rs, input logic [1:0] trs,
                         input logic [4:0] rt, input logic [1:0] trt,
                         input logic [4:0] wa, input logic [1:0] tnew,
                         input logic use_md, input logic start, input logic div);
        id_rs = rs; id_tuse_rs = trs; id_rt = rt; id_tuse_rt = trt;
        id_wa = wa; id_tnew = tnew;
        id_md_use = use_md; id_md_start = start; id_md_div = div;
        #1;
    endtask

    task automatic nop();
        id_in(5'd0, TUSE_NONE, 5'd0, TUSE_NONE, 5'd0, TNEW_NONE, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk3(input string tag, input logic e_id, input logic e_ex, input logic e_busy);
        chk({tag, ".stall_id"}, stall_id, e_id);
        chk({tag, ".stall_ex"}, stall_ex, e_ex);
        chk({tag, ".md_busy"},  md_busy,  e_busy);
    endtask

    initial begin
        // Reset state
        reset = 1'b1;
        nop();
        tick();
        tick();
        chk3("reset", 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        nop();
        tick();

        // Load-use: lw $1 then add $3,$1,$2 -> one stall cycle
        id_in(5'd2, 2'd1, 5'd0, TUSE_NONE, 5'd1, TNEW_LOAD, 1'b0, 1'b0, 1'b0);
        chk3("lu_lw", 1'b0, 1'b0, 1'b0);
        tick();
        id_in(5'd1, 2'd1, 5'd2, 2'd1, 5'd3, TNEW_ALU, 1'b0, 1'b0, 1'b0);
        chk3("lu_c", 1'b1, 1'b0, 1'b0);
        tick();
        chk3("lu_c1", 1'b0, 1'b0, 1'b0);
        tick();
        nop(); tick(); tick();

        // Load to branch: two stall cycles
        id_in(5'd2, 2'd1, 5'd0, TUSE_NONE, 5'd1, TNEW_LOAD, 1'b0, 1'b0, 1'b0);
        tick();
        id_in(5'd1, 2'd0, 5'd0, 2'd0, 5'd0, TNEW_NONE, 1'b0, 1'b0, 1'b0);
        chk("lb_1", stall_id, 1'b1);
        tick();
        chk("lb_2", stall_id, 1'b1);
        tick();
        chk("lb_3", stall_id, 1'b0);
        tick();
        nop(); tick(); tick();

        // ALU to branch: one stall cycle
        id_in(5'd4, 2'd1, 5'd5, 2'd1, 5'd2, TNEW_ALU, 1'b0, 1'b0, 1'b0);
        tick();
        id_in(5'd2, 2'd0, 5'd0, 2'd0, 5'd0, TNEW_NONE, 1'b0, 1'b0, 1'b0);
        chk("ab_1", stall_id, 1'b1);
        tick();
        chk("ab_2", stall_id, 1'b0);
        tick();
        nop(); tick(); tick();

        // Writes to $0 and readers with tuse 3 never stall
        id_in(5'd2, 2'd1, 5'd0, TUSE_NONE, 5'd0, TNEW_LOAD, 1'b0, 1'b0, 1'b0);
        tick();
        id_in(5'd0, 2'd1, 5'd0, 2'd1, 5'd4, TNEW_ALU, 1'b0, 1'b0, 1'b0);
        chk("zero_reg", stall_id, 1'b0);
        tick();
        id_in(5'd2, 2'd1, 5'd0, TUSE_NONE, 5'd5, TNEW_LOAD, 1'b0, 1'b0, 1'b0);
        tick();
        id_in(5'd5, TUSE_NONE, 5'd5, TUSE_NONE, 5'd6, TNEW_ALU, 1'b0, 1'b0, 1'b0);
        chk("tuse_none", stall_id, 1'b0);
        tick();
        nop(); tick(); tick();

        // mult then mflo, with a branch on the mflo result waiting in ID
        id_in(5'd6, 2'd1, 5'd7, 2'd1, 5'd0, TNEW_NONE, 1'b1, 1'b1, 1'b0);
        chk3("mult_id", 1'b0, 1'b0, 1'b0);
        tick();
        id_in(5'd0, TUSE_NONE, 5'd0, TUSE_NONE, 5'd8, TNEW_ALU, 1'b1, 1'b0, 1'b0);
        chk3("mult_t", 1'b0, 1'b0, 1'b0);
        tick();
        id_in(5'd8, 2'd0, 5'd0, 2'd0, 5'd0, TNEW_NONE, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= 5; i++) begin
            chk3($sformatf("mflo_t%0d", i), 1'b0, 1'b1, 1'b1);
            tick();
        end
        chk3("mflo_go", 1'b1, 1'b0, 1'b0);
        tick();
        chk("mflo_after", stall_id, 1'b0);
        tick();
        nop(); tick(); tick();

        // div then div: second waits the full divide
        id_in(5'd6, 2'd1, 5'd7, 2'd1, 5'd0, TNEW_NONE, 1'b1, 1'b1, 1'b1);
        tick();
        chk3("div_t", 1'b0, 1'b0, 1'b0);
        tick();
        nop();
        for (int i = 1; i <= 10; i++) begin
            chk3($sformatf("div2_t%0d", i), 1'b0, 1'b1, 1'b1);
            tick();
        end
        chk3("div2_go", 1'b0, 1'b0, 1'b0);
        tick();
        id_in(5'd0, TUSE_NONE, 5'd0, TUSE_NONE, 5'd9, TNEW_ALU, 1'b1, 1'b0, 1'b0);
        chk3("busy1", 1'b0, 1'b0, 1'b1);
        tick();
        nop();
        chk3("busy2", 1'b0, 1'b1, 1'b1);
        tick();
        chk3("busy3", 1'b0, 1'b1, 1'b1);
        tick();

        // Reset in the 4th busy cycle, with mfhi stuck in EX
        reset = 1'b1;
        #1;
        chk("rst_force.stall_ex", stall_ex, 1'b0);
        chk("rst_force.stall_id", stall_id, 1'b0);
        tick();
        chk3("rst_clr", 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        id_in(5'd0, TUSE_NONE, 5'd0, TUSE_NONE, 5'd9, TNEW_ALU, 1'b1, 1'b0, 1'b0);
        chk3("post_mfhi_id", 1'b0, 1'b0, 1'b0);
        tick();
        nop();
        chk3("post_mfhi_ex", 1'b0, 1'b0, 1'b0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
